// File: rtl/fifo_pkt_rd_ctrl.sv
// fifo_pkt_rd_ctrl: prefetching packet FIFO reader with framing, max-length and IFG enforcement
module fifo_pkt_rd_ctrl #(
  parameter int RD_LATENCY  = 2,
  parameter int BUF_DEPTH   = 4,
  parameter int IFG_CYCLES  = 12,
  parameter int MAX_PKT_LEN = 1518
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  output logic        fifo_rd_en,
  input  logic [9:0]  fifo_rd_data,
  input  logic        fifo_rd_empty,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_abort,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic        busy
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int FW = $clog2(RD_LATENCY + 1);
  localparam int BW = $clog2(MAX_PKT_LEN + 1);
  localparam int IW = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PKT, DROP, IFG} state_t;

  state_t              state, state_n;
  logic [9:0]          mem [BUF_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [RD_LATENCY-1:0] in_sr;
  logic [FW-1:0]       in_flight;
  logic [BW-1:0]       beat_cnt, beat_n;
  logic [IW-1:0]       ifg_cnt, ifg_n;
  logic                pop, pkt_inc, err_inc, cap, head_v, head_sop, head_eop, at_max;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + FW'(in_sr[i]);
  end

  // Reservation counts in-flight reads so returning words always find a free slot
  assign fifo_rd_en = !fifo_rd_empty && !rd_rst && (int'(count) + int'(in_flight) < BUF_DEPTH);
  assign cap        = in_sr[RD_LATENCY-1];
  assign head_v     = count != '0;
  assign head_sop   = mem[rd_ptr][8];
  assign head_eop   = mem[rd_ptr][9];
  assign at_max     = int'(beat_cnt) == MAX_PKT_LEN - 1;
  assign tx_data    = tx_valid ? mem[rd_ptr][7:0] : '0;
  assign busy       = state != IDLE || head_v || |in_sr;

  always_ff @(posedge rd_clk)
    if (cap && !rd_rst) mem[wr_ptr] <= fifo_rd_data;

  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      in_sr  <= '0;
    end else begin
      in_sr  <= (in_sr << 1) | RD_LATENCY'(fifo_rd_en);
      wr_ptr <= cap ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      count  <= count + CW'(cap) - CW'(pop);
    end

  always_comb begin
    state_n  = state;
    beat_n   = beat_cnt;
    ifg_n    = '0;
    pop      = 1'b0;
    pkt_inc  = 1'b0;
    err_inc  = 1'b0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_abort = 1'b0;
    case (state)
      IDLE: if (head_v) begin
        if (head_sop) begin
          tx_valid = 1'b1;
          tx_sop   = 1'b1;
          tx_eop   = head_eop;
          if (tx_ready) begin
            pop     = 1'b1;
            beat_n  = BW'(1);
            pkt_inc = head_eop;
            state_n = head_eop ? IFG : PKT;
          end
        end else begin
          pop     = 1'b1;
          err_inc = 1'b1;
        end
      end
      PKT: if (head_v) begin
        if (head_sop) begin
          tx_abort = 1'b1;
          err_inc  = 1'b1;
          state_n  = IFG;
        end else begin
          tx_valid = 1'b1;
          tx_eop   = head_eop || at_max;
          if (tx_ready) begin
            pop      = 1'b1;
            beat_n   = beat_cnt + 1'b1;
            pkt_inc  = head_eop;
            tx_abort = !head_eop && at_max;
            err_inc  = !head_eop && at_max;
            state_n  = head_eop ? IFG : at_max ? DROP : PKT;
          end
        end
      end
      DROP: if (head_v) begin
        pop     = !head_sop;
        state_n = (head_sop || head_eop) ? IFG : DROP;
      end
      default: begin
        ifg_n   = ifg_cnt + 1'b1;
        state_n = (int'(ifg_cnt) == IFG_CYCLES - 1) ? IDLE : IFG;
      end
    endcase
  end

  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      ifg_cnt  <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      ifg_cnt  <= ifg_n;
      pkt_cnt  <= pkt_cnt + 16'(pkt_inc && pkt_cnt != 16'hFFFF);
      err_cnt  <= err_cnt + 16'(err_inc && err_cnt != 16'hFFFF);
    end
endmodule

// File: tb/tb_fifo_pkt_rd_ctrl.sv
// tb_fifo_pkt_rd_ctrl: directed bench with a 2-cycle-latency FIFO model and beat monitor
module tb_fifo_pkt_rd_ctrl;
  logic        rd_clk = 0, rd_rst = 1;
  logic        fifo_rd_en, fifo_rd_empty = 1;
  logic [9:0]  fifo_rd_data = '0, d1 = '0, w;
  logic [7:0]  tx_data;
  logic        tx_sop, tx_eop, tx_valid, tx_abort, busy, tx_ready = 1;
  logic [15:0] pkt_cnt, err_cnt;
  int          errs = 0, checks = 0, cyc = 0, viol = 0, rd_tot = 0, tx_tot = 0, max_out = 0, b0 = 0, ab0 = 0;
  bit          track = 0;
  logic [9:0]  fq[$], bt[$], exp_q[$];
  int          bt_cyc[$], ab_cyc[$];

  fifo_pkt_rd_ctrl #(.RD_LATENCY(2), .BUF_DEPTH(4), .IFG_CYCLES(12), .MAX_PKT_LEN(8)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_abort(tx_abort), .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO with output register: word read in cycle t is on fifo_rd_data in cycle t+2
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    fifo_rd_data <= d1;
    w = '0;
    if (fifo_rd_en && fq.size() > 0) w = fq.pop_front();
    d1 <= w;
    fifo_rd_empty <= fq.size() == 0;
  end

  always @(negedge rd_clk) begin
    if (fifo_rd_en && fifo_rd_empty) viol++;
    if (fifo_rd_en) rd_tot++;
    if (tx_valid && tx_ready) begin
      bt.push_back({tx_eop, tx_sop, tx_data});
      bt_cyc.push_back(cyc);
      tx_tot++;
    end
    if (tx_abort) ab_cyc.push_back(cyc);
    if (!track) max_out = 0;
    else if (rd_tot - tx_tot > max_out) max_out = rd_tot - tx_tot;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, req);
    end
  endtask

  task automatic chk_pkt(input string tag);
    chk({tag, "_n"}, bt.size() - b0, exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_beat%0d", tag, i), bt[b0 + i], exp_q[i]);
  endtask

  task automatic push_all();
    @(posedge rd_clk);
    #1;
    b0  = bt.size();
    ab0 = ab_cyc.size();
    foreach (exp_q[i]) fq.push_back(exp_q[i]);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 200 && bt.size() - b0 < n; i++) @(negedge rd_clk);
    chk("beat_wait", bt.size() - b0 >= n, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy || fq.size() > 0); i++) @(negedge rd_clk);
    chk("idle_wait", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge rd_clk);
    #1 rd_rst = 1;
    @(posedge rd_clk);
    #1 rd_rst = 0;
  endtask

  initial begin
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 0;
    @(negedge rd_clk);
    chk("rst_outs", {tx_valid, tx_sop, tx_eop, tx_abort, busy, fifo_rd_en}, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_cnts", {pkt_cnt, err_cnt}, 0);
    // two back-to-back packets: 4-beat burst, then exactly 12 idle cycles
    exp_q = '{10'h111, 10'h022, 10'h033, 10'h244, 10'h111, 10'h022, 10'h033, 10'h244};
    push_all();
    wait_beats(8);
    chk_pkt("t1");
    chk("t1_b2b", bt_cyc[b0 + 3] - bt_cyc[b0], 3);
    chk("t1_ifg", bt_cyc[b0 + 4] - bt_cyc[b0 + 3], 13);
    wait_idle();
    chk("t1_pkt", pkt_cnt, 2);
    chk("t1_err", err_cnt, 0);
    // back-pressure toggling every cycle
    do_reset();
    track = 1;
    push_all();
    for (int i = 0; i < 100 && bt.size() - b0 < 8; i++) begin
      @(posedge rd_clk);
      #1 tx_ready = ~tx_ready;
    end
    tx_ready = 1;
    wait_idle();
    track = 0;
    chk_pkt("t2");
    chk("t2_occ", max_out <= 4, 1);
    chk("t2_abort", ab_cyc.size() - ab0, 0);
    chk("t2_pkt", pkt_cnt, 2);
    // stray non-sop word in IDLE
    do_reset();
    exp_q = '{10'h0AA, 10'h155, 10'h266};
    push_all();
    exp_q = '{10'h155, 10'h266};
    wait_beats(2);
    wait_idle();
    chk_pkt("t3");
    chk("t3_err", err_cnt, 1);
    chk("t3_pkt", pkt_cnt, 1);
    // missing eop: abort, gap, then the sop word starts a new packet
    do_reset();
    exp_q = '{10'h101, 10'h002, 10'h103, 10'h204};
    push_all();
    wait_beats(4);
    wait_idle();
    chk_pkt("t4");
    chk("t4_nabort", ab_cyc.size() - ab0, 1);
    chk("t4_abort_cyc", ab_cyc[ab0] - bt_cyc[b0 + 1], 1);
    chk("t4_gap", bt_cyc[b0 + 2] - bt_cyc[b0 + 1], 14);
    chk("t4_err", err_cnt, 1);
    chk("t4_pkt", pkt_cnt, 1);
    // 10-beat packet against an 8-beat limit
    do_reset();
    exp_q = '{10'h150, 10'h051, 10'h052, 10'h053, 10'h054, 10'h055, 10'h056, 10'h057, 10'h058, 10'h259};
    push_all();
    exp_q = '{10'h150, 10'h051, 10'h052, 10'h053, 10'h054, 10'h055, 10'h056, 10'h257};
    wait_beats(8);
    wait_idle();
    chk_pkt("t5");
    chk("t5_nabort", ab_cyc.size() - ab0, 1);
    chk("t5_abort_cyc", ab_cyc[ab0], bt_cyc[b0 + 7]);
    chk("t5_err", err_cnt, 1);
    chk("t5_pkt", pkt_cnt, 0);
    // reset after the first beat while the next two words are still in flight
    exp_q = '{10'h1A0, 10'h0A1, 10'h2A2};
    push_all();
    repeat (4) @(posedge rd_clk);
    #1 rd_rst = 1;
    @(posedge rd_clk);
    #1 rd_rst = 0;
    @(negedge rd_clk);
    chk("t6_pre_beat", bt.size() - b0, 1);
    chk("t6_outs", {tx_valid, tx_sop, tx_eop, tx_abort, busy, fifo_rd_en}, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_cnts", {pkt_cnt, err_cnt}, 0);
    exp_q = '{10'h1B0, 10'h2B1};
    push_all();
    wait_beats(2);
    wait_idle();
    chk_pkt("t6");
    chk("t6_err", err_cnt, 0);
    chk("t6_pkt", pkt_cnt, 1);
    chk("empty_reads", viol, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
